// File: rtl/gb_pulse_ctrl.sv
// ============================================================================
// gb_pulse_ctrl
// ----------------------------------------------------------------------------
// Register front-end and frame sequencer for one APU pulse channel.
//
// The block decodes CPU writes to the channel's NR10..NR14 registers and to
// the APU power register (NR52). It holds the decoded fields and drives them
// to the pulse channel. It also generates:
//   * a one-cycle start trigger whenever NR14 is written with bit 7 set;
//   * the length / sweep / volume-envelope tick strobes, from an 8-step
//     frame sequencer that advances once every FS_DIV clock cycles.
//
// Parameters
//   FS_DIV              clk cycles per frame-sequencer step (>= 2)
//
// Ports
//   clk                 system clock
//   reset               asynchronous, active-low reset
//   wr_en               CPU write strobe
//   addr[2:0]           0=NR10 1=NR11 2=NR12 3=NR13 4=NR14 5=NR52, 6-7 unused
//   wr_data[7:0]        CPU write data
//   rd_data[7:0]        combinational read-back for addr (unused bits read 1)
//   ch_enable           channel enable status, reflected in NR52 bit 0
//   apu_on              power state (NR52 bit 7)
//   sweep_time[2:0]     NR10[6:4]
//   sweep_decreasing    NR10[3]
//   num_sweep_shifts    NR10[2:0]
//   wave_duty[1:0]      NR11[7:6]
//   length[5:0]         NR11[5:0]
//   initial_volume[3:0] NR12[7:4]
//   envelope_increasing NR12[3]
//   num_envelope_sweeps NR12[2:0]
//   frequency[10:0]     {NR14[2:0], NR13[7:0]}
//   single              NR14[6], length enable
//   start               one-cycle channel trigger
//   clk_length_ctr      one-cycle length counter tick (steps 0,2,4,6)
//   clk_vol_env         one-cycle volume envelope tick (step 7)
//   clk_sweep           one-cycle frequency sweep tick (steps 2,6)
// ============================================================================
module gb_pulse_ctrl #(
    parameter int FS_DIV = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    input  logic        ch_enable,
    output logic        apu_on,
    output logic [2:0]  sweep_time,
    output logic        sweep_decreasing,
    output logic [2:0]  num_sweep_shifts,
    output logic [1:0]  wave_duty,
    output logic [5:0]  length,
    output logic [3:0]  initial_volume,
    output logic        envelope_increasing,
    output logic [2:0]  num_envelope_sweeps,
    output logic [10:0] frequency,
    output logic        single,
    output logic        start,
    output logic        clk_length_ctr,
    output logic        clk_vol_env,
    output logic        clk_sweep
);

    localparam int PRESC_W = (FS_DIV > 1) ? $clog2(FS_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(FS_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    localparam logic [2:0] ADDR_NR10 = 3'd0;
    localparam logic [2:0] ADDR_NR11 = 3'd1;
    localparam logic [2:0] ADDR_NR12 = 3'd2;
    localparam logic [2:0] ADDR_NR13 = 3'd3;
    localparam logic [2:0] ADDR_NR14 = 3'd4;
    localparam logic [2:0] ADDR_NR52 = 3'd5;

    localparam logic [2:0] STEP_SWEEP_A = 3'd2;
    localparam logic [2:0] STEP_SWEEP_B = 3'd6;
    localparam logic [2:0] STEP_ENV     = 3'd7;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic               apuOn_q,         apuOn_d;
    logic [6:0]         nr10_q,          nr10_d;
    logic [1:0]         duty_q,          duty_d;
    logic [5:0]         length_q,        length_d;
    logic [7:0]         nr12_q,          nr12_d;
    logic [7:0]         freqLo_q,        freqLo_d;
    logic [2:0]         freqHi_q,        freqHi_d;
    logic               single_q,        single_d;
    logic               start_q,         start_d;
    logic [PRESC_W-1:0] presc_q,         presc_d;
    logic [2:0]         step_q,          step_d;
    logic               lengthTick_q,    lengthTick_d;
    logic               sweepTick_q,     sweepTick_d;
    logic               envTick_q,       envTick_d;

    logic cfgWrite;
    logic powerWrite;
    logic powerOff;
    logic seqWrap;

    // Config registers only accept writes while powered; NR52 is always
    // writable so the APU can be switched back on.
    assign cfgWrite   = wr_en && apuOn_q;
    assign powerWrite = wr_en && (addr == ADDR_NR52);
    assign powerOff   = powerWrite && !wr_data[7];
    assign seqWrap    = apuOn_q && (presc_q == PRESC_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic. The power-off branch comes last so that it overrides
    // any field write, sequencer advance or strobe computed on the same edge.
    // ------------------------------------------------------------------------
    always_comb begin
        apuOn_d      = apuOn_q;
        nr10_d       = nr10_q;
        duty_d       = duty_q;
        length_d     = length_q;
        nr12_d       = nr12_q;
        freqLo_d     = freqLo_q;
        freqHi_d     = freqHi_q;
        single_d     = single_q;
        start_d      = 1'b0;
        presc_d      = presc_q;
        step_d       = step_q;
        lengthTick_d = 1'b0;
        sweepTick_d  = 1'b0;
        envTick_d    = 1'b0;

        if (cfgWrite) begin
            case (addr)
                ADDR_NR10: nr10_d = wr_data[6:0];
                ADDR_NR11: begin
                    duty_d   = wr_data[7:6];
                    length_d = wr_data[5:0];
                end
                ADDR_NR12: nr12_d   = wr_data;
                ADDR_NR13: freqLo_d = wr_data;
                ADDR_NR14: begin
                    freqHi_d = wr_data[2:0];
                    single_d = wr_data[6];
                    start_d  = wr_data[7];
                end
                default: ;
            endcase
        end

        // The strobes are decoded from the step value before it advances, so
        // the tick for step s appears in the cycle after the wrap edge.
        if (apuOn_q) begin
            if (seqWrap) begin
                presc_d      = '0;
                step_d       = step_q + 3'd1;
                lengthTick_d = !step_q[0];
                sweepTick_d  = (step_q == STEP_SWEEP_A) || (step_q == STEP_SWEEP_B);
                envTick_d    = (step_q == STEP_ENV);
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end

        if (powerWrite) begin
            apuOn_d = wr_data[7];
        end

        if (powerOff) begin
            nr10_d       = '0;
            duty_d       = '0;
            length_d     = '0;
            nr12_d       = '0;
            freqLo_d     = '0;
            freqHi_d     = '0;
            single_d     = 1'b0;
            start_d      = 1'b0;
            presc_d      = '0;
            step_d       = '0;
            lengthTick_d = 1'b0;
            sweepTick_d  = 1'b0;
            envTick_d    = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Register update. Reset leaves the APU powered on with the sequencer at
    // its origin, so the first length tick follows FS_DIV cycles later.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            apuOn_q      <= 1'b1;
            nr10_q       <= '0;
            duty_q       <= '0;
            length_q     <= '0;
            nr12_q       <= '0;
            freqLo_q     <= '0;
            freqHi_q     <= '0;
            single_q     <= 1'b0;
            start_q      <= 1'b0;
            presc_q      <= '0;
            step_q       <= '0;
            lengthTick_q <= 1'b0;
            sweepTick_q  <= 1'b0;
            envTick_q    <= 1'b0;
        end else begin
            apuOn_q      <= apuOn_d;
            nr10_q       <= nr10_d;
            duty_q       <= duty_d;
            length_q     <= length_d;
            nr12_q       <= nr12_d;
            freqLo_q     <= freqLo_d;
            freqHi_q     <= freqHi_d;
            single_q     <= single_d;
            start_q      <= start_d;
            presc_q      <= presc_d;
            step_q       <= step_d;
            lengthTick_q <= lengthTick_d;
            sweepTick_q  <= sweepTick_d;
            envTick_q    <= envTick_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read-back mux. Bits that are write-only or unimplemented read as 1.
    // ------------------------------------------------------------------------
    always_comb begin
        rd_data = 8'hFF;
        case (addr)
            ADDR_NR10: rd_data = {1'b1, nr10_q};
            ADDR_NR11: rd_data = {duty_q, 6'h3F};
            ADDR_NR12: rd_data = nr12_q;
            ADDR_NR13: rd_data = 8'hFF;
            ADDR_NR14: rd_data = {1'b1, single_q, 6'h3F};
            ADDR_NR52: rd_data = {apuOn_q, 3'b111, 3'b000, ch_enable};
            default:   rd_data = 8'hFF;
        endcase
    end

    assign apu_on              = apuOn_q;
    assign sweep_time          = nr10_q[6:4];
    assign sweep_decreasing    = nr10_q[3];
    assign num_sweep_shifts    = nr10_q[2:0];
    assign wave_duty           = duty_q;
    assign length              = length_q;
    assign initial_volume      = nr12_q[7:4];
    assign envelope_increasing = nr12_q[3];
    assign num_envelope_sweeps = nr12_q[2:0];
    assign frequency           = {freqHi_q, freqLo_q};
    assign single              = single_q;
    assign start               = start_q;
    assign clk_length_ctr      = lengthTick_q;
    assign clk_vol_env         = envTick_q;
    assign clk_sweep           = sweepTick_q;

endmodule
